alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: Width, 32, operand and HI/LO register width; only 32 is required to be supported.
REQ-002 Parameter: Iters, 32, iteration cycles per multiply/divide; equals Width.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-005 start  input  1  request strobe, sampled on rising clock.
REQ-006 func  input  Alu_Func_T  decoded ALU function code accompanying start.
REQ-007 a  input  32  operand A: rs value, dividend, or Mthi/Mtlo source.
REQ-008 b  input  32  operand B: multiplier or divisor.
REQ-009 flush  input  1  synchronous abort of the operation in flight.
REQ-010 busy  output  1  multiply/divide in progress; high means start is ignored.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 result  output  32  registered Mfhi/Mflo read value.
REQ-013 hi  output  32  HI architectural register.
REQ-014 lo  output  32  LO architectural register.

Function
REQ-015 States: IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 start is accepted only when state is IDLE; when busy it is ignored with no side effect.
REQ-017 Accepted Mthi/Mtlo: next edge hi<=a or lo<=a, respectively; stay in IDLE; done=1 for the following cycle.
REQ-018 Accepted Mfhi/Mflo: next edge result<=hi or result<=lo (pre-edge value); done=1 for the following cycle.
REQ-019 Accepted Muls/Mulu/Divs/Divu: capture |a|, |b| (signed ops) or raw a, b (unsigned ops), plus sign flags and op kind; go to RUN with iteration counter=0.
REQ-020 Accepted with any other func: no state change, no done, and no register update.
REQ-021 RUN multiply: one shift-add step per cycle over a 64-bit accumulator; after Iters cycles go to FIX.
REQ-022 RUN divide: restoring division, one quotient bit per cycle; after Iters cycles go to FIX.
REQ-023 FIX: Muls negates the 64-bit product when the sign of a differs from the sign of b; Divs negates the quotient when the signs differ and gives the remainder the sign of a.
REQ-024 FIX->IDLE edge: multiply writes {hi,lo}=product; divide writes lo=quotient and hi=remainder; done=1 for the following cycle.
REQ-025 Latency: done asserted exactly Iters+2 cycles after the start-sampling edge (34 cycles); busy high for Iters+1 cycles.
REQ-026 Divide by zero (b=0): lo=32'hFFFFFFFF, hi=a (original value), with the same latency; no other indication.
REQ-027 Divs 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no trap.
REQ-028 flush while in RUN/FIX: next edge to IDLE; hi/lo unchanged; no done. flush in IDLE cancels a same-cycle start.
REQ-029 flush takes priority over FIX completion on the same edge.
REQ-030 done is never high for two consecutive cycles from a single request; result changes only on Mfhi/Mflo.
REQ-031 hi/lo hold their values in every cycle except the update edges defined in REQ-017 and REQ-024.

Reset
REQ-032 reset asserted: immediately (no clock needed) state=IDLE, busy=0, done=0, result=0, hi=0, lo=0, iteration counter=0.
REQ-033 reset mid-operation discards the operation; no done after release.
REQ-034 The first start is accepted on the first rising edge at which reset is low.

Verification
REQ-035 Mulu a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles done, hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
REQ-036 Muls a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; Divs a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 Divu a=100 b=0 -> lo=0xFFFFFFFF, hi=100; Divs 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-038 Mthi a=0x1234 then Mfhi -> hi=0x1234, result=0x1234, one done pulse per request.
REQ-039 Start Divu, issue a second start at cycle 5, flush at cycle 10 -> second start ignored, hi/lo unchanged, no done, busy=0 at cycle 11.
REQ-040 Assert reset at cycle 20 of a Mult -> all outputs 0 asynchronously; a new Mulu 6*7 after release -> lo=42, hi=0.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO architectural registers and move-to/from support.
// func_i codes: 1 Muls, 2 Mulu, 3 Divs, 4 Divu, 5 Mthi, 6 Mtlo, 7 Mfhi, 8 Mflo; any other code is ignored.
module alu_muldiv #(
    parameter int Width = 32,
    parameter int Iters = Width
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       func_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    // state   | meaning
    // IDLE    | accepts start; moves complete here in one edge
    // RUN     | one shift-add or restoring-divide step per cycle
    // FIX     | sign correction and HI/LO write-back
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    localparam logic [3:0] FUNC_MULS = 4'h1;
    localparam logic [3:0] FUNC_MULU = 4'h2;
    localparam logic [3:0] FUNC_DIVS = 4'h3;
    localparam logic [3:0] FUNC_DIVU = 4'h4;
    localparam logic [3:0] FUNC_MTHI = 4'h5;
    localparam logic [3:0] FUNC_MTLO = 4'h6;
    localparam logic [3:0] FUNC_MFHI = 4'h7;
    localparam logic [3:0] FUNC_MFLO = 4'h8;

    localparam int CntW = $clog2(Iters);
    localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);

    state_t               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*Width-1:0]   acc_q, acc_d;
    logic [Width-1:0]     mcand_q, mcand_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 is_div_q, is_div_d;
    logic [Width-1:0]     hi_q, hi_d;
    logic [Width-1:0]     lo_q, lo_d;
    logic [Width-1:0]     result_q, result_d;
    logic                 done_q, done_d;

    logic [Width-1:0]     a_abs, b_abs;
    logic [Width:0]       mul_sum;
    logic [Width:0]       div_shift;
    logic [Width:0]       div_diff;
    logic [2*Width-1:0]   prod_neg;
    logic [Width-1:0]     quot, rem;

    assign a_abs = a_i[Width-1] ? (~a_i + 1'b1) : a_i;
    assign b_abs = b_i[Width-1] ? (~b_i + 1'b1) : b_i;

    // Multiply keeps {partial_product, multiplier}; divide keeps {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_q[2*Width-1:Width], acc_q[Width-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign prod_neg = ~acc_q + 1'b1;
    assign quot     = acc_q[Width-1:0];
    assign rem      = acc_q[2*Width-1:Width];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    case (func_i)
                        FUNC_MULS, FUNC_MULU, FUNC_DIVS, FUNC_DIVU: begin
                            logic signed_op;
                            logic [Width-1:0] op_a, op_b;
                            signed_op = (func_i == FUNC_MULS) || (func_i == FUNC_DIVS);
                            op_a      = signed_op ? a_abs : a_i;
                            op_b      = signed_op ? b_abs : b_i;
                            is_div_d  = (func_i == FUNC_DIVS) || (func_i == FUNC_DIVU);
                            sign_a_d  = signed_op & a_i[Width-1];
                            sign_b_d  = signed_op & b_i[Width-1];
                            cnt_d     = '0;
                            state_d   = ST_RUN;
                            if (is_div_d) begin
                                acc_d   = {{Width{1'b0}}, op_a};
                                mcand_d = op_b;
                            end else begin
                                acc_d   = {{Width{1'b0}}, op_b};
                                mcand_d = op_a;
                            end
                        end
                        FUNC_MTHI: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        FUNC_MTLO: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        FUNC_MFHI: begin
                            result_d = hi_q;
                            done_d   = 1'b1;
                        end
                        FUNC_MFLO: begin
                            result_d = lo_q;
                            done_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[Width]) begin
                            acc_d = {div_diff[Width-1:0], acc_q[Width-2:0], 1'b1};
                        end else begin
                            acc_d = {div_shift[Width-1:0], acc_q[Width-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[Width-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // A zero divisor leaves the dividend magnitude in rem, so hi returns a unchanged.
                        if (mcand_q == '0) begin
                            lo_d = '1;
                        end else begin
                            lo_d = (sign_a_q ^ sign_b_q) ? (~quot + 1'b1) : quot;
                        end
                        hi_d = sign_a_q ? (~rem + 1'b1) : rem;
                    end else begin
                        {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? prod_neg : acc_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vectors, flush/reset scenarios, and randomized ops vs. an arithmetic model.
module tb_alu_muldiv;

    localparam logic [3:0] F_MULS = 4'h1;
    localparam logic [3:0] F_MULU = 4'h2;
    localparam logic [3:0] F_DIVS = 4'h3;
    localparam logic [3:0] F_DIVU = 4'h4;
    localparam logic [3:0] F_MTHI = 4'h5;
    localparam logic [3:0] F_MTLO = 4'h6;
    localparam logic [3:0] F_MFHI = 4'h7;
    localparam logic [3:0] F_MFLO = 4'h8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  func  = 4'h0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int passes = 0;

    logic [31:0] hi_m = '0, lo_m = '0, result_m = '0;

    alu_muldiv #(.Width(32), .Iters(32)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .start_i (start),
        .func_i  (func),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .result_o(result),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: architectural effect of one accepted request.
    task automatic model_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                            output int exp_lat, output int exp_busy);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        exp_lat = 34;
        exp_busy = 33;
        case (f)
            F_MULU: begin p = {32'b0, av} * {32'b0, bv}; hi_m = p[63:32]; lo_m = p[31:0]; end
            F_MULS: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
            F_DIVU: begin
                if (bv == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = av; end
                else begin lo_m = av / bv; hi_m = av % bv; end
            end
            F_DIVS: begin
                if (bv == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = av; end
                else begin q = sa / sb; r = sa % sb; lo_m = 32'(q); hi_m = 32'(r); end
            end
            F_MTHI: begin hi_m = av; exp_lat = 1; exp_busy = 0; end
            F_MTLO: begin lo_m = av; exp_lat = 1; exp_busy = 0; end
            F_MFHI: begin result_m = hi_m; exp_lat = 1; exp_busy = 0; end
            F_MFLO: begin result_m = lo_m; exp_lat = 1; exp_busy = 0; end
            default: begin exp_lat = 0; exp_busy = 0; end
        endcase
    endtask

    // Drives one request; called 1ns after a rising edge. lat = cycle index of done (0 if none within 40).
    task automatic run_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int bcyc, output logic dbl);
        func = f; a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0; bcyc = 0; dbl = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcyc++;
            if (done) begin lat = n; break; end
            @(posedge clock); #1;
        end
        if (lat != 0) begin
            @(posedge clock); #1;
            dbl = done;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, result, hi, lo} !== '0) $display("FAIL reset_outputs: got busy=%b done=%b result=%h hi=%h lo=%h, want all 0", busy, done, result, hi, lo);
        else passes++;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        begin
            int lat, bc, el, eb; logic dbl;
            model_op(F_MTLO, 32'h0000_00A5, '0, el, eb);
            run_op(F_MTLO, 32'h0000_00A5, '0, lat, bc, dbl);
            checks++;
            if (lat !== 1) $display("FAIL first_start_latency: got %0d, want 1", lat);
            else passes++;
            checks++;
            if (lo !== 32'h0000_00A5) $display("FAIL first_start_lo: got %h, want 000000a5", lo);
            else passes++;
        end
    endtask

    typedef struct {
        logic [3:0]  f;
        logic [31:0] av, bv, hi_e, lo_e;
    } vec_t;

    task automatic test_vectors();
        vec_t v[6];
        int lat, bc, el, eb; logic dbl;
        v[0] = '{F_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[1] = '{F_MULS, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        v[2] = '{F_DIVS, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{F_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        v[4] = '{F_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[5] = '{F_MULU, 32'd6,         32'd7,         32'd0,         32'd42};
        foreach (v[i]) begin
            model_op(v[i].f, v[i].av, v[i].bv, el, eb);
            run_op(v[i].f, v[i].av, v[i].bv, lat, bc, dbl);
            checks++;
            if (hi !== v[i].hi_e || lo !== v[i].lo_e)
                $display("FAIL vector%0d_hilo: got hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, v[i].hi_e, v[i].lo_e);
            else passes++;
            checks++;
            if (lat !== 34 || bc !== 33 || dbl !== 1'b0)
                $display("FAIL vector%0d_timing: got lat=%0d busy=%0d dbl=%b, want 34 33 0", i, lat, bc, dbl);
            else passes++;
        end
    endtask

    task automatic test_moves();
        int lat, bc, el, eb; logic dbl;
        model_op(F_MTHI, 32'h0000_1234, '0, el, eb);
        run_op(F_MTHI, 32'h0000_1234, '0, lat, bc, dbl);
        checks++;
        if (hi !== 32'h0000_1234 || lat !== 1 || dbl !== 1'b0)
            $display("FAIL mthi: got hi=%h lat=%0d dbl=%b, want 00001234 1 0", hi, lat, dbl);
        else passes++;
        model_op(F_MFHI, '0, '0, el, eb);
        run_op(F_MFHI, '0, '0, lat, bc, dbl);
        checks++;
        if (result !== 32'h0000_1234 || lat !== 1 || dbl !== 1'b0)
            $display("FAIL mfhi: got result=%h lat=%0d dbl=%b, want 00001234 1 0", result, lat, dbl);
        else passes++;
    endtask

    task automatic test_back_to_back();
        func = F_MTLO; a = 32'hCAFE_0001; start = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b1 || lo !== 32'hCAFE_0001) $display("FAIL b2b_mtlo: got done=%b lo=%h, want 1 cafe0001", done, lo);
        else passes++;
        func = F_MFLO;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'hCAFE_0001) $display("FAIL b2b_mflo: got done=%b result=%h, want 1 cafe0001", done, result);
        else passes++;
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b0) $display("FAIL b2b_done_drop: got %b, want 0", done);
        else passes++;
        lo_m = 32'hCAFE_0001;
        result_m = 32'hCAFE_0001;
    endtask

    task automatic test_invalid_and_idle_flush();
        int lat, bc, el, eb; logic dbl;
        logic [31:0] h0, l0, r0;
        h0 = hi; l0 = lo; r0 = result;
        run_op(4'hB, 32'h5555_5555, 32'h3, lat, bc, dbl);
        checks++;
        if (lat !== 0 || bc !== 0 || hi !== h0 || lo !== l0 || result !== r0)
            $display("FAIL invalid_func: got lat=%0d busy=%0d hi=%h lo=%h result=%h", lat, bc, hi, lo, result);
        else passes++;
        flush = 1'b1;
        model_op(4'h0, '0, '0, el, eb);
        run_op(F_MTHI, 32'h7777_7777, '0, lat, bc, dbl);
        flush = 1'b0;
        checks++;
        if (lat !== 0 || hi !== h0) $display("FAIL idle_flush_cancel: got lat=%0d hi=%h, want 0 %h", lat, hi, h0);
        else passes++;
    endtask

    task automatic test_flush_run();
        logic [31:0] h0, l0;
        logic saw_done;
        h0 = hi; l0 = lo; saw_done = 1'b0;
        func = F_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clock); #1; saw_done |= done; end
        func = F_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL flush_busy_mid: got %b, want 1", busy);
        else passes++;
        repeat (4) begin @(posedge clock); #1; saw_done |= done; end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_busy_cycle11: got %b, want 0", busy);
        else passes++;
        repeat (40) begin saw_done |= done; @(posedge clock); #1; end
        checks++;
        if (saw_done !== 1'b0 || hi !== h0 || lo !== l0)
            $display("FAIL flush_run_effect: got done_seen=%b hi=%h lo=%h, want 0 %h %h", saw_done, hi, lo, h0, l0);
        else passes++;
    endtask

    task automatic test_flush_fix();
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        func = F_MULU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (32) begin @(posedge clock); #1; end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL fix_before_flush: got busy=%b done=%b, want 1 0", busy, done);
        else passes++;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0)
            $display("FAIL flush_fix: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h", busy, done, hi, lo, h0, l0);
        else passes++;
    endtask

    task automatic test_reset_midop();
        int lat, bc, el, eb; logic dbl;
        logic saw_done;
        saw_done = 1'b0;
        func = F_MULS; a = 32'h0001_0003; b = 32'hFFF0_0007; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clock); #1; end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, hi, lo} !== '0)
            $display("FAIL async_reset: got busy=%b done=%b result=%h hi=%h lo=%h, want all 0", busy, done, result, hi, lo);
        else passes++;
        hi_m = '0; lo_m = '0; result_m = '0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;
        repeat (40) begin saw_done |= done | busy; @(posedge clock); #1; end
        checks++;
        if (saw_done !== 1'b0) $display("FAIL reset_no_done: got activity=%b, want 0", saw_done);
        else passes++;
        model_op(F_MULU, 32'd6, 32'd7, el, eb);
        run_op(F_MULU, 32'd6, 32'd7, lat, bc, dbl);
        checks++;
        if (lo !== 32'd42 || hi !== 32'd0 || lat !== 34)
            $display("FAIL post_reset_mul: got hi=%h lo=%h lat=%0d, want 0 2a 34", hi, lo, lat);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] corners[5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        for (int it = 0; it < 40; it++) begin
            int idx, lat, bc, el, eb; logic dbl;
            logic [3:0] f; logic [31:0] av, bv;
            idx = $urandom_range(0, 9);
            f = (idx < 8) ? 4'(idx + 1) : ((idx == 8) ? 4'h0 : 4'($urandom_range(9, 15)));
            av = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            bv = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 5) == 0) bv = bv & 32'h0000_00FF;
            model_op(f, av, bv, el, eb);
            run_op(f, av, bv, lat, bc, dbl);
            checks++;
            if (lat !== el || bc !== eb || dbl !== 1'b0)
                $display("FAIL rand%0d_timing f=%0d: got lat=%0d busy=%0d dbl=%b, want %0d %0d 0", it, f, lat, bc, dbl, el, eb);
            else passes++;
            checks++;
            if (hi !== hi_m || lo !== lo_m || result !== result_m)
                $display("FAIL rand%0d_regs f=%0d a=%h b=%h: got hi=%h lo=%h res=%h, want %h %h %h",
                         it, f, av, bv, hi, lo, result, hi_m, lo_m, result_m);
            else passes++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_vectors();
        test_moves();
        test_back_to_back();
        test_invalid_and_idle_flush();
        test_flush_run();
        test_flush_fix();
        test_random();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
